// File: rtl/elixirchip_es1_spu_op_acc.sv
// elixirchip_es1_spu_op_acc
// Pipelined SPU accumulator. Stage 1 holds the running total and adds one
// addend per enabled cycle; stages 2..LATENCY delay the result. Every
// register, the valid pipe included, freezes while cke is low.
//
// Handshake: s_valid / s_clear are sampled only on clk edges with cke=1 and
// are never back-pressured. m_valid is a one-cycle-per-result strobe (held
// while cke is low) marking the cycle in which m_data / m_carry took a new
// value; m_data / m_carry are stable in every other cycle.
module elixirchip_es1_spu_op_acc #(
  parameter int    LATENCY    = 1,
  parameter int    DATA_BITS  = 8,
  parameter type   data_t     = logic [DATA_BITS-1:0],
  parameter data_t CLEAR_DATA = '0,
  parameter data_t RESET_DATA = '0,
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  cke,
  input  data_t s_data,
  input  logic  s_clear,
  input  logic  s_valid,
  output data_t m_data,
  output logic  m_carry,
  output logic  m_valid
);

  // Keep the arrays well-formed even for an illegal LATENCY so the range
  // check below is what reports the problem.
  localparam int STAGES = (LATENCY < 1) ? 1 : LATENCY;

  // Elaboration-time range check on LATENCY.
  if (SIMULATION == "true") begin : g_sim_check
    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
      $error("elixirchip_es1_spu_op_acc: LATENCY=%0d outside 1..8 (DEVICE=%s DEBUG=%s)",
             LATENCY, DEVICE, DEBUG);
    end
  end

  // Stage 1 is the accumulator itself; the last stage drives the outputs.
  data_t             st_data  [1:STAGES];
  logic              st_carry [1:STAGES];
  logic [STAGES:1]   st_valid;

  data_t             base;
  logic [DATA_BITS:0] sum;

  // Clear substitutes CLEAR_DATA for the feedback so clear+add is one update.
  always_comb begin
    base = s_clear ? CLEAR_DATA : st_data[1];
    sum  = {1'b0, base} + {1'b0, s_data};
  end

  // Accumulator stage plus delay stages; later stages only load on a valid
  // result so the outputs stay stable between results.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= STAGES; k++) begin
        st_data[k]  <= RESET_DATA;
        st_carry[k] <= 1'b0;
      end
      st_valid <= '0;
    end else if (cke) begin
      if (s_valid) begin
        st_data[1]  <= sum[DATA_BITS-1:0];
        st_carry[1] <= sum[DATA_BITS];
      end else if (s_clear) begin
        st_data[1]  <= CLEAR_DATA;
        st_carry[1] <= 1'b0;
      end
      st_valid[1] <= s_valid | s_clear;
      for (int k = 2; k <= STAGES; k++) begin
        st_valid[k] <= st_valid[k-1];
        if (st_valid[k-1]) begin
          st_data[k]  <= st_data[k-1];
          st_carry[k] <= st_carry[k-1];
        end
      end
    end
  end

  assign m_data  = st_data[STAGES];
  assign m_carry = st_carry[STAGES];
  assign m_valid = st_valid[STAGES];

endmodule

// File: tb/tb_elixirchip_es1_spu_op_acc.sv
// Bench for elixirchip_es1_spu_op_acc: four instances with different
// LATENCY / DATA_BITS share one stimulus stream; each has a reference model
// feeding an expected queue and an independent output monitor.
module tb_elixirchip_es1_spu_op_acc;

  logic        clk;
  logic        reset;
  logic        cke;
  logic        s_valid;
  logic        s_clear;
  logic [63:0] s_data_all;
  logic        drain_done;

  int checks;
  int failures;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- comparison helper ----------------
  function automatic void check(input int inst, input string name,
                                input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL inst%0d %s actual=0x%0h expected=0x%0h t=%0t", inst, name, act, exp, $time);
    end
  endfunction

  // ---------------- DUT instances, models, monitors ----------------
  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int          W    = (g == 2) ? 33 : (g == 3) ? 1 : 8;
    localparam int          L    = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 2 : 3;
    localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;
    localparam logic [63:0] CLR  = ((g == 2) ? 64'h1_2345_6789 : 64'h05) & MASK;
    localparam logic [63:0] RST  = ((g == 1) ? 64'h3C : (g == 2) ? 64'h1_0000_0001 :
                                    (g == 3) ? 64'h1 : 64'h0) & MASK;

    logic [W-1:0] m_data;
    logic         m_carry;
    logic         m_valid;

    elixirchip_es1_spu_op_acc #(
      .LATENCY    (L),
      .DATA_BITS  (W),
      .CLEAR_DATA (CLR[W-1:0]),
      .RESET_DATA (RST[W-1:0]),
      .SIMULATION ("true")
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .cke     (cke),
      .s_data  (s_data_all[W-1:0]),
      .s_clear (s_clear),
      .s_valid (s_valid),
      .m_data  (m_data),
      .m_carry (m_carry),
      .m_valid (m_valid)
    );

    // expected entry: {due edge index[31:0], carry, data[63:0]}
    logic [96:0] exp_q[$];
    logic [63:0] acc        = RST;
    int          cnt        = 0;
    int          last_edge  = 2;    // 0 reset, 1 enabled edge, 2 frozen edge
    logic [63:0] held_data  = RST;
    logic        held_carry = 1'b0;
    logic        held_valid = 1'b0;

    // Reference model: running sum mod 2^W; a result accepted on enabled
    // edge n is due on enabled edge n+L-1.
    always @(posedge clk) begin : model
      logic [63:0] base;
      logic [63:0] sum;
      logic        c;
      if (reset) begin
        acc       = RST;
        exp_q.delete();
        last_edge = 0;
      end else if (cke) begin
        cnt++;
        last_edge = 1;
        if (s_valid || s_clear) begin
          base = s_clear ? CLR : acc;
          if (s_valid) begin
            sum = base + (s_data_all & MASK);
            acc = sum & MASK;
            c   = sum[W];
          end else begin
            acc = CLR;
            c   = 1'b0;
          end
          exp_q.push_back({32'(cnt + L - 1), c, acc});
        end
      end else begin
        last_edge = 2;
      end
    end

    // Monitor: compare each result in the cycle it is due; otherwise the
    // outputs must not move.
    always @(negedge clk) begin : monitor
      logic [96:0] e;
      if (last_edge == 0) begin
        check(g, "reset_valid", 64'(m_valid), 64'd0);
        check(g, "reset_data",  64'(m_data),  RST);
        check(g, "reset_carry", 64'(m_carry), 64'd0);
        held_data  = RST;
        held_carry = 1'b0;
        held_valid = 1'b0;
      end else if (last_edge == 1 && exp_q.size() > 0 && exp_q[0][96:65] == 32'(cnt)) begin
        e = exp_q.pop_front();
        check(g, "result_valid", 64'(m_valid), 64'd1);
        check(g, "result_data",  64'(m_data),  e[63:0]);
        check(g, "result_carry", 64'(m_carry), 64'(e[64]));
        held_data  = e[63:0];
        held_carry = e[64];
        held_valid = 1'b1;
      end else begin
        if (last_edge == 1) held_valid = 1'b0;
        check(g, "idle_valid", 64'(m_valid), 64'(held_valid));
        check(g, "stable_data",  64'(m_data),  held_data);
        check(g, "stable_carry", 64'(m_carry), 64'(held_carry));
      end
    end

    // Every issued result must have come out by the end of the drain.
    always @(posedge drain_done) begin
      check(g, "queue_empty", 64'(exp_q.size()), 64'd0);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic ck, input logic v,
                       input logic c, input logic [63:0] d);
    reset      = rst;
    cke        = ck;
    s_valid    = v;
    s_clear    = c;
    s_data_all = d;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks     = 0;
    failures   = 0;
    drain_done = 1'b0;

    drive(1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);   // reset wins over cke=0

    // consecutive adds 3,4,5
    drive(1'b0, 1'b1, 1'b1, 1'b0, 64'd3);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 64'd4);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 64'd5);
    idle(5);

    // clear+add to 0xF0, then overflow to 0x10, then 0x11 without carry
    drive(1'b0, 1'b1, 1'b1, 1'b1, 64'hEB);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h20);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h01);
    idle(5);

    // accumulate to 0x40, clear+add 2, then clear alone
    drive(1'b0, 1'b1, 1'b1, 1'b1, 64'h3B);
    idle(2);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 64'h02);
    idle(2);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h00);
    idle(5);

    // one add, then two frozen cycles with inputs that must be ignored
    drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h09);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 64'h07);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h11);
    idle(6);

    // three results in flight, then reset discards them
    drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h21);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h22);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h23);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h00);
    idle(6);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 9) < 8),
            ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 9) == 0),
            {$urandom(), $urandom()});
    end

    idle(12);
    drain_done = 1'b1;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
